register_serial_tx: RTL and testbench
=====================================

# register_serial_tx

Serial transmitter that sits downstream of the 5-bit load/clear register and ships its parallel contents out over a single-wire, UART-style line. It accepts a 5-bit word with a `load` handshake and frames it as start bit, 5 data bits (LSB first), an optional parity bit, and a stop bit. Each bit is held for a programmable number of clocks. It is the transmitting end of the register's data path; a matching serial receiver reassembles the word on the far side.

## Interface
- `WIDTH`, default 5: data word width.
- `CLKS_PER_BIT`, default 4: clocks per serial bit; legal range 1..255.

- `clock` input 1: single system clock; all logic uses the rising edge.
- `reset_n` input 1: asynchronous, active-low reset; one clock, no other clock domains.
- `register_in` input WIDTH: parallel word to send, sampled on acceptance.
- `load` input 1: request to send; accepted on a rising edge when `ready`=1 and `clear`=0.
- `clear` input 1: synchronous abort; returns the block to idle.
- `serial_out` output 1: serial line; idles high.
- `ready` output 1: high when idle and able to accept `load`.
- `done` output 1: one-cycle pulse when a frame's stop bit completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY (present only when compiled in), STOP.
- IDLE:
  - `serial_out`=1 and `ready`=1.
  - On accepted `load`: capture `register_in` into the shift register, clear the bit timer and bit index, then go to START.
- START: `serial_out`=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - `serial_out` = shift register bit 0; shift right on each bit boundary.
  - After WIDTH bits, go to PARITY if compiled in, otherwise STOP.
- PARITY: `serial_out` = even parity (XOR of the captured word) for CLKS_PER_BIT cycles, then STOP.
- STOP:
  - `serial_out`=1 for CLKS_PER_BIT cycles, then IDLE.
  - `done`=1 in the first IDLE cycle only.
- `load` while `ready`=0 is ignored and has no effect on the frame in flight. `register_in` changes after acceptance are ignored.
- `clear` in any state:
  - Next edge: IDLE, `serial_out`=1, `done`=0; the captured word is discarded.
  - `clear` and `load` on the same edge: `clear` wins and `load` is dropped.
- Reset values: state IDLE, `serial_out`=1, `ready`=1, `done`=0, shift register 0, counters 0.
- Reset asserted mid-frame aborts immediately and asynchronously; no partial stop bit is sent.
- Bit timer counts 0..CLKS_PER_BIT-1 and wraps. The bit index counts 0..WIDTH-1. Neither counter may overflow for the legal parameter range.

## Timing
- Latency: `load` accepted at edge N; `serial_out` falls at edge N+1.
- Each bit lasts exactly CLKS_PER_BIT cycles.
- Frame length F = (WIDTH+2)·CLKS_PER_BIT cycles, or (WIDTH+3)·CLKS_PER_BIT with parity.
- `ready` falls at edge N+1 and rises at edge N+1+F, in the same cycle that `done`=1.
- Back-to-back: a `load` presented in the `done` cycle is accepted. The next start bit then follows the stop bit with no idle gap.
- `serial_out`, `ready` and `done` are registered (or decoded from registered state only), with no combinational path from inputs.

## Configuration
- Macro: `REGISTER_SERIAL_TX_PARITY_EN`.
- Defined: the PARITY state is present and an even-parity bit is inserted between the last data bit and the stop bit. Frame = WIDTH+3 bits.
- Undefined: the PARITY state and the parity XOR logic are not compiled. Frame = WIDTH+2 bits.

## Structure
- Shared package `register_serial_pkg` holds:
  - the FSM state typedef;
  - constants IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1.
- The matching receiver imports the same package.
- One sub-module, `bit_timer`:
  - counts CLKS_PER_BIT and emits a one-cycle `bit_tick` at each bit boundary;
  - restarted by the FSM on acceptance and on `clear`.

## Test plan
- Reset with CLKS_PER_BIT=2, no load → `serial_out`=1, `ready`=1, `done`=0 for 20 cycles.
- `load` with `register_in`=5'd3, no parity → `serial_out` per 2-cycle bit: 0,1,1,0,0,0,1. `ready` low for 14 cycles; `done` pulses once at frame end.
- Parity build, `register_in`=5'd7 → data bits 1,1,1,0,0, then parity 1, then stop 1. Frame is 16 cycles.
- Second `load` (5'd22) asserted mid-frame → ignored; the frame still carries the first word. A `load` of 5'd22 in the `done` cycle → start bit begins on the next edge, and bits 0,1,1,0,1 follow.
- `clear` during DATA bit 2 → next edge `serial_out`=1 and `ready`=1, with no `done` pulse. `clear` and `load` on the same edge → no frame starts.
- `reset_n` low mid-frame (between edges) → `serial_out`=1 and `ready`=1 immediately, without waiting for a clock edge. After release, a `load` of 5'd10 sends 0,1,0,1,0 correctly.

Source files
------------

// File: rtl/register_serial_tx_pkg.sv
// Shared definitions for the register serial link (transmitter and receiver).
// Optional feature macro: REGISTER_SERIAL_TX_PARITY_EN adds the PARITY state.
package register_serial_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef REGISTER_SERIAL_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } tx_state_e;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/register_serial_tx_if.sv
// Bus between the 5-bit register side and the serial transmitter.
// Handshake: a word is taken on a rising edge where load=1, ready=1 and
// clear=0; ready stays low until the frame is finished, load at any other
// time is ignored, and clear aborts the frame and wins over load.
interface register_serial_tx_if #(
   parameter int WIDTH = 5
);
   import register_serial_pkg::*;

   logic [WIDTH-1:0] register_in;
   logic             load;
   logic             clear;
   logic             serial_out;
   logic             ready;
   logic             done;
   tx_state_e        state;      // FSM state, exported for debug/checkers

   modport master (
      output register_in, load, clear,
      input  serial_out, ready, done, state
   );

   modport slave (
      input  register_in, load, clear,
      output serial_out, ready, done, state
   );
endinterface

// File: rtl/register_serial_tx_bit_timer.sv
// Bit timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each serial bit with bit_tick_o.
module bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clock,
   input  logic reset_n,
   input  logic restart_i,
   input  logic enable_i,
   output logic bit_tick_o
);
   // 8 bits hold the largest legal count (254) without overflow.
   localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

   logic [7:0] cnt_q, cnt_d;

   // Next count: restart wins, otherwise wrap at the end of a bit.
   always_comb begin
      cnt_d = cnt_q;
      if (restart_i) begin
         cnt_d = 8'd0;
      end else if (enable_i) begin
         cnt_d = (cnt_q == LAST_CNT) ? 8'd0 : cnt_q + 8'd1;
      end
   end

   // Count register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) cnt_q <= 8'd0;
      else          cnt_q <= cnt_d;
   end

   assign bit_tick_o = enable_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/register_serial_tx.sv
// UART-style transmitter for the 5-bit load/clear register: start bit,
// WIDTH data bits LSB first, optional even parity, stop bit.
// Optional feature macro: REGISTER_SERIAL_TX_PARITY_EN.
// All outputs are flops loaded from the next-state decode, so they follow
// the state register exactly and have no combinational path from inputs.
module register_serial_tx
   import register_serial_pkg::*;
#(
   parameter int WIDTH        = 5,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                 clock,
   input  logic                 reset_n,
   register_serial_tx_if.slave  bus
);
   localparam int             IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0]  LAST_IDX = IW'(WIDTH - 1);

   tx_state_e        state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [IW-1:0]    idx_q,   idx_d;
   logic             serial_q, serial_d;
   logic             ready_q,  ready_d;
   logic             done_q,   done_d;
`ifdef REGISTER_SERIAL_TX_PARITY_EN
   logic             parity_q, parity_d;
`endif
   logic             restart;
   logic             bit_tick;
   logic             accept;

   // ready_q is high exactly when the registered state is IDLE.
   assign accept = bus.load && ready_q && !bus.clear;

   bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clock      (clock),
      .reset_n    (reset_n),
      .restart_i  (restart),
      .enable_i   (state_q != IDLE),
      .bit_tick_o (bit_tick)
   );

   // Next-state, datapath and output decode.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      idx_d    = idx_q;
      restart  = 1'b0;
      done_d   = 1'b0;
`ifdef REGISTER_SERIAL_TX_PARITY_EN
      parity_d = parity_q;
`endif
      if (bus.clear) begin
         state_d = IDLE;
         shift_d = '0;
         idx_d   = '0;
         restart = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_d  = START;
                  shift_d  = bus.register_in;
                  idx_d    = '0;
                  restart  = 1'b1;
`ifdef REGISTER_SERIAL_TX_PARITY_EN
                  parity_d = ^bus.register_in;
`endif
               end
            end
            START: begin
               if (bit_tick) state_d = DATA;
            end
            DATA: begin
               if (bit_tick) begin
                  shift_d = shift_q >> 1;
                  if (idx_q == LAST_IDX) begin
                     idx_d = '0;
`ifdef REGISTER_SERIAL_TX_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end else begin
                     idx_d = idx_q + IW'(1);
                  end
               end
            end
`ifdef REGISTER_SERIAL_TX_PARITY_EN
            PARITY: begin
               if (bit_tick) state_d = STOP;
            end
`endif
            STOP: begin
               if (bit_tick) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      ready_d = (state_d == IDLE);
      case (state_d)
         START:   serial_d = START_LEVEL;
         DATA:    serial_d = shift_d[0];
`ifdef REGISTER_SERIAL_TX_PARITY_EN
         PARITY:  serial_d = parity_d;
`endif
         STOP:    serial_d = STOP_LEVEL;
         default: serial_d = IDLE_LEVEL;
      endcase
   end

   // State and output registers; reset drops the line to idle at once.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         idx_q    <= '0;
         serial_q <= IDLE_LEVEL;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
`ifdef REGISTER_SERIAL_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         idx_q    <= idx_d;
         serial_q <= serial_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
`ifdef REGISTER_SERIAL_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign bus.serial_out = serial_q;
   assign bus.ready      = ready_q;
   assign bus.done       = done_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_register_serial_tx.sv
// Directed bench for register_serial_tx with CLKS_PER_BIT=2, WIDTH=5.
// Build with +define+REGISTER_SERIAL_TX_PARITY_EN to cover the parity frame.
module tb_register_serial_tx;
   import register_serial_pkg::*;

   localparam int W = 5;
   localparam int C = 2;
`ifdef REGISTER_SERIAL_TX_PARITY_EN
   localparam int NBITS = W + 3;
`else
   localparam int NBITS = W + 2;
`endif
   localparam int F = NBITS * C;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   register_serial_tx_if #(.WIDTH(W)) bus ();

   register_serial_tx #(
      .WIDTH        (W),
      .CLKS_PER_BIT (C)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // ---------------- scoreboard ----------------
   int         n_total = 0;
   int         n_bad   = 0;
   logic [0:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Expected line levels for one frame, one entry per clock.
   task automatic build_frame(input logic [W-1:0] w);
      exp_q.delete();
      for (int k = 0; k < C; k++) exp_q.push_back(1'b0);
      for (int b = 0; b < W; b++)
         for (int k = 0; k < C; k++) exp_q.push_back(w[b]);
`ifdef REGISTER_SERIAL_TX_PARITY_EN
      for (int k = 0; k < C; k++) exp_q.push_back(^w);
`endif
      for (int k = 0; k < C; k++) exp_q.push_back(1'b1);
   endtask

   task automatic start_frame(input logic [W-1:0] w);
      bus.register_in = w;
      bus.load        = 1'b1;
      step();
      bus.load        = 1'b0;
   endtask

   // Called in the first START cycle. Optionally pokes a load mid-frame and
   // optionally chains a new load in the done cycle.
   task automatic run_frame(input logic [W-1:0] w, input int mid_at,
                            input bit chain, input logic [W-1:0] next_w);
      logic [0:0] e;
      build_frame(w);
      for (int i = 0; i < F; i++) begin
         if (i == mid_at) begin
            bus.load        = 1'b1;
            bus.register_in = 5'd22;
         end else if (i == mid_at + 1) begin
            bus.load = 1'b0;
         end
         e = exp_q.pop_front();
         check_eq($sformatf("serial w=%0d i=%0d", w, i), 32'(bus.serial_out), 32'(e));
         check_eq($sformatf("ready_low w=%0d i=%0d", w, i), 32'(bus.ready), 32'd0);
         check_eq($sformatf("done_low w=%0d i=%0d", w, i), 32'(bus.done), 32'd0);
         step();
      end
      check_eq("done_pulse", 32'(bus.done), 32'd1);
      check_eq("ready_end", 32'(bus.ready), 32'd1);
      check_eq("serial_end", 32'(bus.serial_out), 32'd1);
      if (chain) begin
         bus.register_in = next_w;
         bus.load        = 1'b1;
      end
      step();
      bus.load = 1'b0;
      check_eq("done_once", 32'(bus.done), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset_n         = 1'b0;
      bus.load        = 1'b0;
      bus.clear       = 1'b0;
      bus.register_in = '0;
      step();
      step();
      reset_n = 1'b1;

      // Idle after reset.
      for (int i = 0; i < 20; i++) begin
         check_eq("idle_serial", 32'(bus.serial_out), 32'd1);
         check_eq("idle_ready", 32'(bus.ready), 32'd1);
         check_eq("idle_done", 32'(bus.done), 32'd0);
         step();
      end

      // Plain frame of 3.
      start_frame(5'd3);
      run_frame(5'd3, -1, 1'b0, '0);

      // Word 7 (parity frame when compiled in).
      start_frame(5'd7);
      run_frame(5'd7, -1, 1'b0, '0);

      // Mid-frame load of 22 ignored; 22 loaded in the done cycle follows.
      start_frame(5'd3);
      run_frame(5'd3, 5, 1'b1, 5'd22);
      run_frame(5'd22, -1, 1'b0, '0);

      // Clear during DATA bit 2.
      start_frame(5'd3);
      build_frame(5'd3);
      for (int i = 0; i < 3 * C; i++) begin
         check_eq($sformatf("pre_clear i=%0d", i), 32'(bus.serial_out), 32'(exp_q.pop_front()));
         step();
      end
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
      check_eq("clear_serial", 32'(bus.serial_out), 32'd1);
      check_eq("clear_ready", 32'(bus.ready), 32'd1);
      for (int i = 0; i < F; i++) begin
         check_eq("clear_no_done", 32'(bus.done), 32'd0);
         check_eq("clear_idle", 32'(bus.serial_out), 32'd1);
         step();
      end

      // Clear and load together: no frame.
      bus.register_in = 5'd5;
      bus.load        = 1'b1;
      bus.clear       = 1'b1;
      step();
      bus.load  = 1'b0;
      bus.clear = 1'b0;
      for (int i = 0; i < 2 * C; i++) begin
         check_eq("clr_load_serial", 32'(bus.serial_out), 32'd1);
         check_eq("clr_load_ready", 32'(bus.ready), 32'd1);
         step();
      end

      // Asynchronous reset mid-frame.
      start_frame(5'd22);
      step();
      step();
      step();
      #2 reset_n = 1'b0;
      #1;
      check_eq("rst_serial", 32'(bus.serial_out), 32'd1);
      check_eq("rst_ready", 32'(bus.ready), 32'd1);
      check_eq("rst_done", 32'(bus.done), 32'd0);
      step();
      reset_n = 1'b1;
      step();
      check_eq("post_rst_serial", 32'(bus.serial_out), 32'd1);
      start_frame(5'd10);
      run_frame(5'd10, -1, 1'b0, '0);

      // ---------------- report ----------------
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
